// File: rtl/rx_deser_pkg.sv
// Shared definitions for the RX deserializer: FSM states, parity encodings
// and the legal DATA_WIDTH range.
package rx_deser_pkg;

  localparam int unsigned DATA_WIDTH_MIN = 5;
  localparam int unsigned DATA_WIDTH_MAX = 9;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/param_rx_deserializer.sv
// Collects majority-voted serial bits into a parallel word, with optional
// even/odd parity check.
// Ports:
//   CLK, RST     - clock, asynchronous active-high reset
//   deser_en     - frame window from the RX FSM
//   bit_ready    - one-cycle strobe qualifying sampled_bit
//   sampled_bit  - serial data / parity bit
//   par_en       - frame carries a parity bit (sampled at frame start)
//   par_type     - 0 even, 1 odd (sampled at frame start)
//   P_DATA       - last completed frame
//   data_valid   - one-cycle pulse when P_DATA is newly loaded
//   par_err      - parity result of the last completed frame
//   overrun      - one-cycle pulse when a strobe arrived with nowhere to go
module param_rx_deserializer
  import rx_deser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  deser_en,
  input  logic                  bit_ready,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  overrun
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  if ((DATA_WIDTH < DATA_WIDTH_MIN) || (DATA_WIDTH > DATA_WIDTH_MAX)) begin : g_bad_width
    $error("param_rx_deserializer: DATA_WIDTH out of range");
  end

  rx_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                  acc_q, acc_d;
  logic                  pen_q, pen_d;
  logic                  ptype_q, ptype_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  perr_q, perr_d;
  logic                  ovr_q, ovr_d;

  // Candidate shadow/accumulator values if the current strobe is captured
  logic [IDX_W-1:0]      bit_pos;
  logic [DATA_WIDTH-1:0] shadow_cap;
  logic                  acc_cap;
  logic                  par_calc;

  always_comb begin
    bit_pos             = MSB_FIRST ? (IDX_LAST - idx_q) : idx_q;
    shadow_cap          = shadow_q;
    shadow_cap[bit_pos] = sampled_bit;
    acc_cap             = acc_q ^ sampled_bit;
    par_calc            = acc_cap ? PAR_ODD : PAR_EVEN;
  end

  // Next-state logic; index and accumulator are cleared on every return to
  // IDLE so the capture path in IDLE always starts from bit 0.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    pen_d    = pen_q;
    ptype_d  = ptype_q;
    p_data_d = p_data_q;
    perr_d   = perr_q;
    dv_d     = 1'b0;
    ovr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        acc_d = 1'b0;
        if (deser_en) begin
          state_d = ST_SHIFT;
          pen_d   = par_en;
          ptype_d = par_type;
          if (bit_ready) begin
            shadow_d = shadow_cap;
            acc_d    = acc_cap;
            idx_d    = IDX_W'(1);
          end
        end else if (bit_ready) begin
          ovr_d = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (!deser_en) begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          acc_d    = 1'b0;
          shadow_d = '0;
        end else if (bit_ready) begin
          shadow_d = shadow_cap;
          acc_d    = acc_cap;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (pen_q) begin
              state_d = ST_PARITY;
            end else begin
              state_d  = ST_DONE;
              p_data_d = shadow_cap;
              perr_d   = 1'b0;
              dv_d     = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (!deser_en) begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          acc_d    = 1'b0;
          shadow_d = '0;
        end else if (bit_ready) begin
          state_d  = ST_DONE;
          p_data_d = shadow_q;
          perr_d   = (par_calc != ptype_q);
          dv_d     = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        acc_d   = 1'b0;
        if (bit_ready) begin
          ovr_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        acc_d   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      acc_q    <= 1'b0;
      pen_q    <= 1'b0;
      ptype_q  <= 1'b0;
      p_data_q <= '0;
      dv_q     <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      pen_q    <= pen_d;
      ptype_q  <= ptype_d;
      p_data_q <= p_data_d;
      dv_q     <= dv_d;
      perr_q   <= perr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_param_rx_deserializer.sv
// Self-checking bench for param_rx_deserializer: LSB-first and MSB-first
// 8-bit instances share stimulus, a 5-bit instance covers the narrow width.
module tb_param_rx_deserializer;

  logic       CLK;
  logic       RST;
  logic       deser_en, bit_ready, sampled_bit, par_en, par_type;
  logic [7:0] p_data_l, p_data_m;
  logic       dv_l, perr_l, ovr_l;
  logic       dv_m, perr_m, ovr_m;

  logic       deser_en5, bit_ready5, sampled_bit5;
  logic [4:0] p_data5;
  logic       dv5, perr5, ovr5;

  param_rx_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .RST(RST), .deser_en(deser_en), .bit_ready(bit_ready),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_type(par_type),
    .P_DATA(p_data_l), .data_valid(dv_l), .par_err(perr_l), .overrun(ovr_l)
  );

  param_rx_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .CLK(CLK), .RST(RST), .deser_en(deser_en), .bit_ready(bit_ready),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_type(par_type),
    .P_DATA(p_data_m), .data_valid(dv_m), .par_err(perr_m), .overrun(ovr_m)
  );

  param_rx_deserializer #(.DATA_WIDTH(5), .MSB_FIRST(1'b0)) dut_5 (
    .CLK(CLK), .RST(RST), .deser_en(deser_en5), .bit_ready(bit_ready5),
    .sampled_bit(sampled_bit5), .par_en(1'b0), .par_type(1'b0),
    .P_DATA(p_data5), .data_valid(dv5), .par_err(perr5), .overrun(ovr5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       pb;
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
    logic       exp_perr;
  } vec_t;

  exp_t q_l[$];
  exp_t q_m[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Drive one full 8-bit frame; expected results go to the scoreboard when
  // the final strobe is driven.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic pb, input logic ovr_in_done,
                            input logic [7:0] e_l, input logic [7:0] e_m,
                            input logic e_perr);
    exp_t el;
    exp_t em;
    logic last;
    el.data = e_l; el.perr = e_perr;
    em.data = e_m; em.perr = e_perr;
    deser_en = 1'b1;
    par_en   = pe;
    par_type = pt;
    for (int i = 0; i < 8; i++) begin
      bit_ready   = 1'b1;
      sampled_bit = d[i];
      last        = (i == 7) && !pe;
      if (last) begin
        q_l.push_back(el);
        q_m.push_back(em);
      end
      @(negedge CLK);
      bit_ready = 1'b0;
      if (!last) @(negedge CLK);
    end
    if (pe) begin
      bit_ready   = 1'b1;
      sampled_bit = pb;
      q_l.push_back(el);
      q_m.push_back(em);
      @(negedge CLK);
      bit_ready = 1'b0;
    end
    check("dv_latency", 32'(dv_l), 32'd1);
    deser_en = 1'b0;
    par_en   = 1'b0;
    par_type = 1'b0;
    if (ovr_in_done) begin
      bit_ready   = 1'b1;
      sampled_bit = 1'b1;
      @(negedge CLK);
      bit_ready = 1'b0;
      check("overrun_done", 32'(ovr_l), 32'd1);
      check("dv_pulse_width", 32'(dv_l), 32'd0);
      @(negedge CLK);
      check("overrun_done_width", 32'(ovr_l), 32'd0);
    end else begin
      @(negedge CLK);
      check("dv_pulse_width", 32'(dv_l), 32'd0);
    end
  endtask

  // Single strobe followed by one idle cycle, frame window untouched
  task automatic strobe(input logic b);
    bit_ready   = 1'b1;
    sampled_bit = b;
    @(negedge CLK);
    bit_ready = 1'b0;
    @(negedge CLK);
  endtask

  vec_t vecs[7];

  initial begin
    logic [7:0] rd;
    logic       rpe, rpt, rpb, rperr;
    logic [4:0] s5;

    vecs[0] = '{8'h35, 1'b0, 1'b0, 1'b0, 8'h35, 8'hAC, 1'b0};
    vecs[1] = '{8'h35, 1'b1, 1'b0, 1'b0, 8'h35, 8'hAC, 1'b0};
    vecs[2] = '{8'h35, 1'b1, 1'b0, 1'b1, 8'h35, 8'hAC, 1'b1};
    vecs[3] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3, 8'hC3, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0};
    vecs[6] = '{8'h6E, 1'b1, 1'b0, 1'b1, 8'h6E, 8'h76, 1'b0};

    RST = 1'b1;
    deser_en = 1'b0; bit_ready = 1'b0; sampled_bit = 1'b0;
    par_en = 1'b0; par_type = 1'b0;
    deser_en5 = 1'b0; bit_ready5 = 1'b0; sampled_bit5 = 1'b0;

    // Scoreboard consumer for both 8-bit instances
    fork
      forever begin
        exp_t e;
        @(negedge CLK);
        if (!RST) begin
          if (dv_l) begin
            if (q_l.size() == 0) check("dv_unexpected_lsb", 32'(dv_l), 32'd0);
            else begin
              e = q_l.pop_front();
              check("p_data_lsb", 32'(p_data_l), 32'(e.data));
              check("par_err_lsb", 32'(perr_l), 32'(e.perr));
            end
          end
          if (dv_m) begin
            if (q_m.size() == 0) check("dv_unexpected_msb", 32'(dv_m), 32'd0);
            else begin
              e = q_m.pop_front();
              check("p_data_msb", 32'(p_data_m), 32'(e.data));
              check("par_err_msb", 32'(perr_m), 32'(e.perr));
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge CLK);
    check("reset_p_data", 32'(p_data_l), 32'd0);
    check("reset_dv", 32'(dv_l), 32'd0);
    check("reset_par_err", 32'(perr_l), 32'd0);
    check("reset_overrun", 32'(ovr_l), 32'd0);
    check("reset_p_data_msb", 32'(p_data_m), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 7; i++)
      send_frame(vecs[i].d, vecs[i].pe, vecs[i].pt, vecs[i].pb, 1'b0,
                 vecs[i].exp_lsb, vecs[i].exp_msb, vecs[i].exp_perr);

    // Random frames checked against a small reference model
    for (int i = 0; i < 4; i++) begin
      rd    = 8'($urandom);
      rpe   = 1'($urandom);
      rpt   = 1'($urandom);
      rpb   = 1'($urandom);
      rperr = rpe ? (((^rd) ^ rpb) != rpt) : 1'b0;
      send_frame(rd, rpe, rpt, rpb, 1'b0, rd, rev8(rd), rperr);
    end

    // Abort after three strobes leaves the previous frame in place
    send_frame(8'h35, 1'b0, 1'b0, 1'b0, 1'b0, 8'h35, 8'hAC, 1'b0);
    deser_en = 1'b1;
    strobe(1'b0); strobe(1'b1); strobe(1'b1);
    deser_en = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort_keeps_p_data", 32'(p_data_l), 32'h35);
    check("abort_keeps_p_data_msb", 32'(p_data_m), 32'hAC);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hC3, 1'b0);

    // Strobe during DONE, then a clean frame
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 8'h96, 8'h69, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b0);

    // Strobe in IDLE with the window closed
    bit_ready = 1'b1;
    @(negedge CLK);
    bit_ready = 1'b0;
    check("overrun_idle", 32'(ovr_l), 32'd1);
    @(negedge CLK);
    check("overrun_idle_width", 32'(ovr_l), 32'd0);

    // Asynchronous reset after four bits of a frame
    deser_en = 1'b1;
    strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_p_data", 32'(p_data_l), 32'd0);
    check("async_rst_p_data_msb", 32'(p_data_m), 32'd0);
    check("async_rst_dv", 32'(dv_l), 32'd0);
    check("async_rst_par_err", 32'(perr_l), 32'd0);
    check("async_rst_overrun", 32'(ovr_l), 32'd0);
    deser_en = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h5A, 1'b0);

    // Narrow instance: stream 1,1,0,0,1 LSB-first
    s5 = 5'b10011;
    deser_en5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bit_ready5   = 1'b1;
      sampled_bit5 = s5[i];
      @(negedge CLK);
      bit_ready5 = 1'b0;
      if (i != 4) @(negedge CLK);
    end
    check("w5_dv", 32'(dv5), 32'd1);
    check("w5_p_data", 32'(p_data5), 32'h13);
    check("w5_par_err", 32'(perr5), 32'd0);
    deser_en5 = 1'b0;
    @(negedge CLK);
    check("w5_dv_width", 32'(dv5), 32'd0);

    repeat (3) @(negedge CLK);
    check("scoreboard_empty_lsb", 32'(q_l.size()), 32'd0);
    check("scoreboard_empty_msb", 32'(q_m.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_rx_deserializer.md
PARAM_RX_DESERIALIZER -- requirements
Module: param_rx_deserializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, serial data bits per frame; legal range 5..9.
REQ-002 Parameter MSB_FIRST, default 0; 0 = first received bit lands in P_DATA[0], 1 = first received bit lands in P_DATA[DATA_WIDTH-1].
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 deser_en  input  1  frame window from the RX FSM; high while data and parity bits are being received.
REQ-006 bit_ready  input  1  single-cycle strobe, sampled_bit valid when high.
REQ-007 sampled_bit  input  1  majority-voted serial bit.
REQ-008 par_en  input  1  1 = frame carries a parity bit after the data bits; sampled at frame start.
REQ-009 par_type  input  1  0 = even, 1 = odd; sampled at frame start.
REQ-010 P_DATA  output  DATA_WIDTH  last completed frame, registered.
REQ-011 data_valid  output  1  one-cycle pulse, P_DATA newly loaded.
REQ-012 par_err  output  1  parity result of last completed frame, registered, valid with data_valid.
REQ-013 overrun  output  1  one-cycle pulse, a bit was dropped.

Function
REQ-014 FSM states IDLE, SHIFT, PARITY, DONE; internal bit index 0..DATA_WIDTH-1, shadow register, running XOR accumulator.
REQ-015 IDLE: index=0, accumulator=0; deser_en high -> SHIFT, latching par_en/par_type; a bit_ready coincident with this transition is captured as bit 0.
REQ-016 SHIFT: on bit_ready with deser_en high, write sampled_bit to shadow[index] (MSB_FIRST=0) or shadow[DATA_WIDTH-1-index] (MSB_FIRST=1), XOR into accumulator, index+1.
REQ-017 SHIFT exit on capture of bit DATA_WIDTH-1: latched par_en=1 -> PARITY, else -> DONE.
REQ-018 PARITY: on bit_ready, par_err_next = (accumulator XOR sampled_bit) != latched par_type; -> DONE.
REQ-019 On the edge that captures the final bit (data, or parity when enabled), P_DATA <= completed shadow, par_err <= result (0 when parity disabled), data_valid high for exactly the following cycle; latency = 1 cycle from final strobe.
REQ-020 DONE lasts one cycle, then -> IDLE; P_DATA and par_err hold until the next completed frame.
REQ-021 deser_en low in SHIFT or PARITY: abort to IDLE next edge; shadow discarded; no data_valid; P_DATA/par_err unchanged.
REQ-022 bit_ready in DONE, or in IDLE with deser_en low: bit dropped, overrun pulses one cycle; no state change.
REQ-023 bit_ready low: no state/data change except the REQ-021 abort.
REQ-024 Index never wraps; index DATA_WIDTH is unreachable by construction.

Reset
REQ-025 RST high: state IDLE, index 0, shadow 0, accumulator 0, P_DATA 0, data_valid 0, par_err 0, overrun 0, immediately and independent of CLK.
REQ-026 RST mid-frame discards the partial frame; first frame after release starts cleanly from IDLE.

Structure
REQ-027 Shared package rx_deser_pkg holds the state enumeration and PAR_EVEN/PAR_ODD constants; DATA_WIDTH range limits declared there.
REQ-028 Single flat module; no sub-module is warranted.

Verification
REQ-029 W=8, MSB_FIRST=0, par_en=0, stream 1,0,1,0,1,1,0,0 -> P_DATA=0x35, data_valid pulse 1 cycle after 8th strobe, par_err=0.
REQ-030 MSB_FIRST=1, same stream -> P_DATA=0xAC.
REQ-031 par_en=1, par_type=0, 0x35 data then parity 0 -> par_err=0; repeat with parity 1 -> par_err=1, P_DATA=0x35 both frames.
REQ-032 deser_en dropped after 3 strobes -> no data_valid, P_DATA keeps prior 0x35; next full frame 0xC3 received correctly.
REQ-033 bit_ready during DONE cycle -> overrun pulse 1 cycle, next frame unaffected; RST asserted after 4 bits -> all outputs 0 asynchronously.
REQ-034 DATA_WIDTH=5, stream 1,1,0,0,1 LSB-first -> P_DATA=5'h13.
